sram_write_buffer: RTL and testbench

Posted-write buffer and SRAM access scheduler between the cache controller and the SRAM controller. It absorbs data-memory writes into a small FIFO so the pipeline does not stall for SRAM write latency. It drains buffered writes to the SRAM controller in the background and serialises cache read-miss fills against them. Reads that hit a pending write's block are held until that data has reached SRAM.

---
 rtl/sram_wb_pkg.sv | 8 +
 rtl/sram_wb_fifo.sv | 43 ++++
 rtl/sram_write_buffer.sv | 71 +++++++
 tb/tb_sram_write_buffer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_wb_pkg.sv
// sram_wb_pkg: FSM states, block-address range and FIFO entry width shared by sram_write_buffer.
package sram_wb_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  localparam int BLK_LSB = 1;
  function automatic int entry_w(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction
endpackage

// File: rtl/sram_wb_fifo.sv
// sram_wb_fifo: posted-write FIFO of {addr, data} entries with per-entry valid/block-address taps.
import sram_wb_pkg::*;
module sram_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64,
  parameter int BW = 31
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              din,
  output logic [W-1:0]              head,
  output logic                      full,
  output logic                      empty,
  output logic [DEPTH-1:0]          valid,
  output logic [DEPTH-1:0][BW-1:0]  blks
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  assign head = mem[rd_ptr];
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  // a slot is live when its distance from the read pointer is below the occupancy
  for (genvar i = 0; i < DEPTH; i++) begin : g_e
    assign valid[i] = {1'b0, PW'(PW'(i) - rd_ptr)} < count;
    assign blks[i] = mem[i][W-1 -: BW];
  end
endmodule

// File: rtl/sram_write_buffer.sv
// sram_write_buffer: posted-write buffer and SRAM read/write scheduler.
// Define SRAM_WB_READ_PRIORITY_EN to let non-hazard reads bypass pending writes.
import sram_wb_pkg::*;
module sram_write_buffer #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_rd,
  input  logic                req_wr,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                req_ready,
  output logic [2*DATA_W-1:0] req_rdata,
  output logic                sram_rd_en,
  output logic                sram_wr_en,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [2*DATA_W-1:0] sram_rdata,
  input  logic                sram_ready
);
  localparam int EW = entry_w(ADDR_W, DATA_W);
  localparam int BW = ADDR_W - BLK_LSB;
  state_t state, state_nx;
  logic push, pop, full, empty, rd_req, go_rd, wr_pend;
  logic [EW-1:0] head, issue;
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0][BW-1:0] blks;
  sram_wb_fifo #(.DEPTH(DEPTH), .W(EW), .BW(BW)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din({req_addr, req_wdata}),
    .head(head), .full(full), .empty(empty), .valid(valid), .blks(blks)
  );
  assign push = req_wr && !full;
  assign pop = state == WR && sram_ready;
  assign rd_req = req_rd && !req_wr;
  // a write arriving into an empty FIFO is issued straight from the request port
  assign wr_pend = !empty || push;
  assign issue = empty ? {req_addr, req_wdata} : head;
`ifdef SRAM_WB_READ_PRIORITY_EN
  logic hazard;
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) hazard |= valid[i] && blks[i] == req_addr[ADDR_W-1:BLK_LSB];
  end
  assign go_rd = rd_req && !hazard;
`else
  logic unused_hz;
  assign unused_hz = ^{valid, blks};
  assign go_rd = rd_req && empty;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = go_rd ? RD : wr_pend ? WR : IDLE;
    else if (sram_ready) state_nx = IDLE;
    sram_rd_en = state == RD;
    sram_wr_en = state == WR;
    req_ready = !rst && (push || (state == RD && sram_ready));
    req_rdata = state == RD && sram_ready ? sram_rdata : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sram_addr <= '0;
      sram_wdata <= '0;
    end else if (state == IDLE && go_rd) sram_addr <= req_addr;
    else if (state == IDLE && wr_pend) {sram_addr, sram_wdata} <= issue;
endmodule

// File: tb/tb_sram_write_buffer.sv
// tb_sram_write_buffer: directed tests with an ordering/occupancy model and an SRAM responder.
module tb_sram_write_buffer;
  localparam int DEPTH = 4;
  logic clk, rst, req_rd, req_wr, req_ready, sram_rd_en, sram_wr_en, sram_ready;
  logic [31:0] req_addr, req_wdata, sram_addr, sram_wdata;
  logic [63:0] req_rdata, sram_rdata;
  int n_chk = 0, n_fail = 0, lat = 3, busy = 0;
  bit late = 0, in_op = 0, prev_done = 0;
  logic [31:0] op_addr, op_data;
  logic [63:0] expq[$];
  logic [31:0] oplog[$];
  logic [63:0] smem [logic [30:0]];

  sram_write_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .req_rdata(req_rdata),
    .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // SRAM controller: completes an operation after lat strobe cycles
  always @(posedge clk) begin
    #1;
    if (rst || !(sram_rd_en || sram_wr_en)) begin
      busy = 0;
      sram_ready = late;
    end else begin
      busy++;
      sram_ready = late || busy == lat;
      if (sram_rd_en) sram_rdata = smem.exists(sram_addr[31:1]) ? smem[sram_addr[31:1]] : 64'h0;
      if (sram_wr_en && busy == lat) begin
        if (!smem.exists(sram_addr[31:1])) smem[sram_addr[31:1]] = 64'h0;
        if (sram_addr[0]) smem[sram_addr[31:1]][63:32] = sram_wdata;
        else smem[sram_addr[31:1]][31:0] = sram_wdata;
      end
    end
  end

  // compare process: occupancy, ordering, hazards, stability and gaps
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_strobes", {sram_rd_en, sram_wr_en}, 0);
      chk("rst_addr", {sram_addr, sram_wdata}, 0);
      chk("rst_rdata", req_rdata, 0);
      expq.delete();
      in_op = 0;
      prev_done = 0;
    end else begin
      chk("req_ready", req_ready, (req_wr && expq.size() < DEPTH) || (sram_rd_en && sram_ready));
      chk("strobe_excl", sram_rd_en && sram_wr_en, 0);
      if (prev_done) chk("op_gap", {sram_rd_en, sram_wr_en}, 0);
      if (sram_rd_en || sram_wr_en) begin
        if (!in_op) begin
          in_op = 1;
          op_addr = sram_addr;
          op_data = sram_wdata;
          oplog.push_back(sram_addr);
          if (sram_wr_en) begin
            if (expq.size() == 0) chk("wr_unexpected", 1, 0);
            else chk("wr_order", {sram_addr, sram_wdata}, expq[0]);
          end else begin
            chk("rd_addr", {req_rd, sram_addr}, {1'b1, req_addr});
`ifdef SRAM_WB_READ_PRIORITY_EN
            begin
              int hits = 0;
              foreach (expq[i]) if (expq[i][63:33] == sram_addr[31:1]) hits++;
              chk("rd_hazard", hits, 0);
            end
`else
            chk("rd_strict", expq.size(), 0);
`endif
          end
        end else chk("op_stable", {sram_addr, sram_wdata}, {op_addr, op_data});
        if (sram_ready) begin
          if (sram_wr_en) void'(expq.pop_front());
          else chk("rd_data", req_rdata, sram_rdata);
          in_op = 0;
        end
      end
      prev_done = sram_ready && (sram_rd_en || sram_wr_en);
      if (req_wr && req_ready) expq.push_back({req_addr, req_wdata});
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, output int w);
    req_wr = 1; req_addr = a; req_wdata = d; w = 0;
    while (1) begin
      @(negedge clk);
      if (req_ready) break;
      w++;
      if (w > 200) begin chk("wr_timeout", 0, 1); break; end
      tick;
    end
    tick;
    req_wr = 0;
  endtask

  task automatic do_read(input logic [31:0] a, output int w, output logic [63:0] d);
    req_rd = 1; req_addr = a; w = 0; d = '0;
    while (1) begin
      @(negedge clk);
      if (req_ready) begin d = req_rdata; break; end
      w++;
      if (w > 200) begin chk("rd_timeout", 0, 1); break; end
      tick;
    end
    tick;
    req_rd = 0;
  endtask

  task automatic wait_quiet;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (expq.size() == 0 && !sram_rd_en && !sram_wr_en) break;
    end
    chk("drained", expq.size(), 0);
    tick;
  endtask

  initial begin
    int w, n;
    logic [63:0] d;
    logic [31:0] e5 [5];
    logic [31:0] e3 [3];
    rst = 1; req_rd = 0; req_wr = 1; req_addr = 32'h0; req_wdata = 32'h0;
    sram_ready = 0; sram_rdata = 64'h0;
    tick; tick;
    req_wr = 0;
    tick;
    rst = 0;
    tick;

    // single write, latency 3
    lat = 3;
    do_write(32'h400, 32'hAAAA0001, w);
    chk("w1_ready_same_cycle", w, 0);
    @(negedge clk);
    chk("w1_strobe_next", sram_wr_en, 1);
    chk("w1_addr", sram_addr, 32'h400);
    chk("w1_data", sram_wdata, 32'hAAAA0001);
    n = 1;
    for (int k = 0; k < 20 && sram_wr_en; k++) begin
      @(negedge clk);
      if (sram_wr_en) n++;
    end
    chk("w1_strobe_len", n, 3);
    repeat (4) begin
      @(negedge clk);
      chk("w1_fifo_empty", {sram_rd_en, sram_wr_en}, 0);
    end
    tick;

    // five back-to-back writes, latency 4
    lat = 4;
    oplog.delete();
    e5 = '{32'h10, 32'h12, 32'h14, 32'h16, 32'h18};
    for (int i = 0; i < 5; i++) begin
      do_write(e5[i], 32'hD000 + i, w);
      chk("b2b_wait", w, i < 4 ? 0 : 1);
    end
    wait_quiet;
    chk("b2b_count", oplog.size(), 5);
    for (int i = 0; i < 5 && i < oplog.size(); i++) chk("b2b_order", oplog[i], e5[i]);

    // read behind a same-block write, latency 2
    lat = 2;
    do_write(32'h500, 32'h55550000, w);
    do_read(32'h501, w, d);
    chk("hz_wait", w, 4);
    chk("hz_data", d, 64'h00000000_55550000);
    wait_quiet;

    // read on an empty buffer
    do_read(32'h400, w, d);
    chk("rd_latency", w, 2);
    chk("rd_data_lit", d, 64'h00000000_AAAA0001);
    wait_quiet;

    // read against two pending writes, latency 3
    lat = 3;
    oplog.delete();
    do_write(32'h600, 32'h1, w);
    do_write(32'h608, 32'h2, w);
    do_read(32'h700, w, d);
`ifdef SRAM_WB_READ_PRIORITY_EN
    chk("pri_wait", w, 5);
    e3 = '{32'h600, 32'h700, 32'h608};
`else
    chk("strict_wait", w, 9);
    e3 = '{32'h600, 32'h608, 32'h700};
`endif
    chk("pri_data", d, 64'h0);
    wait_quiet;
    chk("pri_count", oplog.size(), 3);
    for (int i = 0; i < 3 && i < oplog.size(); i++) chk("pri_order", oplog[i], e3[i]);

    // reset mid-write with entries queued
    lat = 10;
    do_write(32'h800, 32'h8, w);
    do_write(32'h802, 32'h9, w);
    do_write(32'h804, 32'hA, w);
    chk("mid_strobe", sram_wr_en, 1);
    #2;
    req_wr = 1; req_addr = 32'hC00; rst = 1;
    #1;
    chk("rst_drop_strobe", {sram_rd_en, sram_wr_en}, 0);
    chk("rst_drop_ready", req_ready, 0);
    chk("rst_drop_addr", sram_addr, 0);
    late = 1;
    tick;
    req_wr = 0;
    tick;
    rst = 0;
    tick;
    late = 0;
    oplog.delete();
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_idle", {sram_rd_en, sram_wr_en}, 0);
    end
    tick;
    lat = 2;
    do_write(32'hC00, 32'hC0C0, w);
    chk("post_rst_accept", w, 0);
    wait_quiet;
    chk("post_rst_ops", oplog.size(), 1);
    if (oplog.size() > 0) chk("post_rst_op", oplog[0], 32'hC00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
